bt656_line_decoder: RTL
=======================

// Module: bt656_line_decoder
// PURPOSE
//  Decodes the 8-bit ITU-R BT.656 stream from the TV decoder into 4:2:2 pixel-pair words.
//  Stream format: TD_DATA at 27 MHz; TRS codes FF 00 00 XY; active data ordered Cb Y Cr Y.
//  Sits directly upstream of the display input / line-buffer stage and supplies it with:
//  field, active-line and pixel-pair indices, and line-start / field-start pulses.
//  Detects TRS codes, checks the XY protection bits, and reports lock and error status.
// PARAMETERS
//  ACTIVE_BYTES  1440  bytes of active video per line (720 px, 4:2:2)
//  MAX_LINES     288   active lines per field; line_y saturates at MAX_LINES-1
// PORTS
//  TD_CLK27     in   1   27 MHz decoder pixel clock; all logic on rising edge
//  RESET        in   1   asynchronous, active-high reset
//  TD_DATA      in   8   BT.656 byte stream
//  yuv_data     out  32  {Cb, Y0, Cr, Y1} of one pixel pair
//  yuv_valid    out  1   one-cycle strobe: yuv_data, pix_x and line_y are valid
//  pix_x        out  9   pixel-pair index within the line, 0..359
//  line_y       out  9   active-line index within the current field
//  field        out  1   F bit of the last good TRS
//  line_start   out  1   one-cycle pulse on a good SAV with V=0
//  field_start  out  1   one-cycle pulse on the first such SAV after V goes 1->0
//  trs_error    out  1   one-cycle pulse on an XY protection-bit mismatch
//  locked       out  1   high once a good EAV has been seen; cleared by trs_error
// BEHAVIOUR
//  Reset
//   - All outputs are 0; the shift register is cleared to 00.
//   - State = BLANK, counters = 0, V_prev = 1.
//   - Reset mid-line aborts any partial word; no yuv_valid is issued for it.
//  Input pipeline and latency
//   - 4-byte shift register b3..b0; each edge samples TD_DATA into b0.
//   - All outputs are registered and reflect the decode of b3..b0 one edge later.
//   - Net latency: 2 edges from a byte on TD_DATA to its effect at the outputs.
//  TRS detection
//   - TRS is {b3,b2,b1} == FF,00,00; XY = b0; bit7 must be 1.
//   - XY fields: F = XY[6], V = XY[5], H = XY[4] (1 = EAV, 0 = SAV).
//   - Protection check: XY[3:0] == {V^H, F^H, F^V, F^V^H}.
//   - Mismatch or XY[7] == 0: pulse trs_error, clear locked, force BLANK, ignore the code.
//   - TRS detection always runs, including inside ACTIVE.
//   - Good TRS: update field from F.
//  State machine
//   - BLANK -> ACTIVE on a good SAV with V=0.
//     Clears the byte counter and phase, and pulses line_start.
//     If V_prev == 1, also pulses field_start and clears line_y.
//     V_prev is updated on every good TRS.
//   - ACTIVE: each non-TRS byte advances phase 0..3 and is stored as Cb / Y0 / Cr / Y1.
//     On phase 3, yuv_valid pulses with pix_x = pair count.
//     The pair count increments and wraps to 0 at each line_start.
//   - ACTIVE -> BLANK when a good EAV arrives.
//     If ACTIVE_BYTES were not received, the partial word is dropped.
//     line_y increments on EAV, saturating at MAX_LINES-1.
//   - ACTIVE -> BLANK after ACTIVE_BYTES bytes even without an EAV.
//     Further bytes are ignored until the next SAV.
//   - TRS bytes (FF,00,00,XY) never produce yuv_valid.
//     The FF/00/00 preamble bytes already counted in ACTIVE are discarded
//     when the code completes; this holds because FF never appears in video data.
//  Blanking and status
//   - SAV with V=1 (vertical blanking) does not enter ACTIVE.
//   - locked goes high on a good EAV, or stays high; trs_error clears it on the same edge.
//   - Good EAV and error pulses are mutually exclusive (a byte is one code only).
// TESTING
//  1. Reset, then FF 00 00 80 (SAV F0 V0) then 80 10 80 10 x360.
//     -> line_start=1 once, field_start=1, 360 yuv_valid strobes,
//        yuv_data=32'h80108010, pix_x 0..359.
//  2. The same line followed by FF 00 00 9D (EAV F0 V0).
//     -> locked=1, line_y 0->1, next SAV gives line_start=1 with field_start=0.
//  3. Send XY=0x81 (bad protection) mid-stream.
//     -> trs_error pulses one cycle, locked=0, state BLANK, no yuv_valid until the next good SAV.
//  4. SAV then only 1001 data bytes then EAV.
//     -> 250 strobes, last pix_x=249, no strobe for the trailing byte.
//  5. SAV F1 V1 (XY=EC), then SAV F1 V0 (XY=C7).
//     -> field=1, no capture during V=1, field_start on the C7 SAV, line_y=0.
//  6. Assert RESET mid-line after 2 bytes of a pair.
//     -> all outputs 0 asynchronously, no yuv_valid after release until a new SAV.

Source files
------------

// File: rtl/bt656_line_decoder.sv
// ---------------------------------------------------------------------------
// bt656_line_decoder
//
// Decodes an 8-bit ITU-R BT.656 byte stream (27 MHz, TRS codes FF 00 00 XY,
// active video ordered Cb Y Cr Y) into 4:2:2 pixel-pair words for the
// downstream line-buffer stage, together with field / line / pixel indices,
// line and field start pulses, protection-bit error and lock status.
//
// Ports
//   TD_CLK27     in   1   pixel clock, all logic on the rising edge
//   RESET        in   1   asynchronous active-high reset
//   TD_DATA      in   8   BT.656 byte stream
//   yuv_data     out  32  {Cb, Y0, Cr, Y1} of one pixel pair
//   yuv_valid    out  1   strobe: yuv_data / pix_x / line_y valid
//   pix_x        out  9   pixel-pair index within the line
//   line_y       out  9   active-line index within the field (saturating)
//   field        out  1   F bit of the last good TRS
//   line_start   out  1   pulse on a good SAV with V=0
//   field_start  out  1   pulse on the first such SAV after V went 1->0
//   trs_error    out  1   pulse on an XY protection mismatch
//   locked       out  1   set by a good EAV, cleared by trs_error
//
// Latency: a byte on TD_DATA is captured into the shift register on one
// edge and its decode is visible on the registered outputs on the next.
// ---------------------------------------------------------------------------
module bt656_line_decoder #(
    parameter int ACTIVE_BYTES = 1440,
    parameter int MAX_LINES    = 288
) (
    input  logic        TD_CLK27,
    input  logic        RESET,
    input  logic [7:0]  TD_DATA,
    output logic [31:0] yuv_data,
    output logic        yuv_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  line_y,
    output logic        field,
    output logic        line_start,
    output logic        field_start,
    output logic        trs_error,
    output logic        locked
);

    localparam int BC_W = $clog2(ACTIVE_BYTES + 1);

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // XY byte: bit7 must be set and the low nibble must carry the
    // protection bits derived from F, V and H.
    function automatic logic xy_ok(input logic [7:0] xy);
        logic f;
        logic v;
        logic h;
        f = xy[6];
        v = xy[5];
        h = xy[4];
        return xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    endfunction

    // -----------------------------------------------------------------------
    // Stage 0: byte shift register, b0 holds the newest byte
    // -----------------------------------------------------------------------
    logic [7:0] b3, b2, b1, b0;

    always_ff @(posedge TD_CLK27 or posedge RESET) begin
        if (RESET) begin
            b3 <= 8'h00;
            b2 <= 8'h00;
            b1 <= 8'h00;
            b0 <= 8'h00;
        end else begin
            b3 <= b2;
            b2 <= b1;
            b1 <= b0;
            b0 <= TD_DATA;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: decode of b3..b0 into registered outputs
    // -----------------------------------------------------------------------
    logic trs_hit;
    logic trs_good;
    logic trs_bad;
    logic xy_f;
    logic xy_v;
    logic xy_h;
    logic preamble;

    assign trs_hit  = (b3 == 8'hFF) && (b2 == 8'h00) && (b1 == 8'h00);
    assign trs_good = trs_hit && xy_ok(b0);
    assign trs_bad  = trs_hit && !xy_ok(b0);
    assign xy_f     = b0[6];
    assign xy_v     = b0[5];
    assign xy_h     = b0[4];

    // FF never occurs in video data, so an FF (and the 00 00 that follows
    // it) is the start of a TRS preamble. These bytes are dropped from the
    // pixel stream as they arrive, so a preamble interrupting a short line
    // can never complete a pixel pair.
    assign preamble = (b0 == 8'hFF)
                   || ((b1 == 8'hFF) && (b0 == 8'h00))
                   || ((b2 == 8'hFF) && (b1 == 8'h00) && (b0 == 8'h00));

    state_t          state;
    logic [1:0]      phase;
    logic [BC_W-1:0] byte_cnt;
    logic [8:0]      pair_cnt;
    logic            v_prev;
    logic            line_open;   // a line was started and its EAV is pending
    logic            cap_en;

    assign cap_en = (state == ACTIVE) && !trs_hit && !preamble;

    // Partial-pair holding registers; only ever read once all four bytes of
    // a pair have arrived, so they need no reset.
    logic [7:0] cb_hold;
    logic [7:0] y0_hold;
    logic [7:0] cr_hold;

    always_ff @(posedge TD_CLK27) begin
        if (cap_en) begin
            case (phase)
                2'd0:    cb_hold <= b0;
                2'd1:    y0_hold <= b0;
                2'd2:    cr_hold <= b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge TD_CLK27 or posedge RESET) begin
        if (RESET) begin
            state       <= BLANK;
            phase       <= 2'd0;
            byte_cnt    <= '0;
            pair_cnt    <= 9'd0;
            v_prev      <= 1'b1;
            line_open   <= 1'b0;
            yuv_data    <= 32'h0;
            yuv_valid   <= 1'b0;
            pix_x       <= 9'd0;
            line_y      <= 9'd0;
            field       <= 1'b0;
            line_start  <= 1'b0;
            field_start <= 1'b0;
            trs_error   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            yuv_valid   <= 1'b0;
            line_start  <= 1'b0;
            field_start <= 1'b0;
            trs_error   <= 1'b0;

            if (trs_bad) begin
                // Corrupt code: ignore its content and drop any partial line.
                trs_error <= 1'b1;
                locked    <= 1'b0;
                state     <= BLANK;
            end else if (trs_good) begin
                field  <= xy_f;
                v_prev <= xy_v;
                if (xy_h) begin
                    // EAV: any partial pair is simply abandoned.
                    locked <= 1'b1;
                    state  <= BLANK;
                    if (line_open) begin
                        line_open <= 1'b0;
                        if (line_y != 9'(MAX_LINES - 1))
                            line_y <= line_y + 9'd1;
                    end
                end else if (!xy_v) begin
                    // SAV outside vertical blanking opens a new line.
                    state      <= ACTIVE;
                    phase      <= 2'd0;
                    byte_cnt   <= '0;
                    pair_cnt   <= 9'd0;
                    line_open  <= 1'b1;
                    line_start <= 1'b1;
                    if (v_prev) begin
                        field_start <= 1'b1;
                        line_y      <= 9'd0;
                    end
                end
            end else if (cap_en) begin
                phase    <= phase + 2'd1;
                byte_cnt <= byte_cnt + 1'b1;
                if (phase == 2'd3) begin
                    yuv_valid <= 1'b1;
                    yuv_data  <= {cb_hold, y0_hold, cr_hold, b0};
                    pix_x     <= pair_cnt;
                    pair_cnt  <= pair_cnt + 9'd1;
                end
                // Line is complete once the nominal byte count is reached,
                // whether or not an EAV follows.
                if (byte_cnt == BC_W'(ACTIVE_BYTES - 1))
                    state <= BLANK;
            end
        end
    end

endmodule
